panel_key_seq: RTL and testbench

- Front-panel momentary-key sequencer for the PDP-8/I console. Sits directly downstream of the per-key glitch filters and consumes their filtered level and one-cycle positive-edge outputs.
- Turns key presses into single, arbitrated console commands with a req/ack handshake to the CPU's console logic.
- Enforces key lockout: all keys released, then a hold-off period, before the next command is accepted.
- Handles STOP as an immediate pulse, independent of the sequencer.

---
 rtl/panel_key_seq.sv | 129 ++++++++++++
 tb/tb_panel_key_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_key_seq.sv
// PDP-8/I front-panel momentary-key sequencer: arbitrates filtered key edges into
// single console commands with req/ack, key lockout with hold-off, and an immediate STOP pulse.
//
// state   | meaning
// IDLE    | armed, waiting for a key edge
// ISSUE   | command presented, waiting for ack or timeout
// RELEASE | waiting for all keys to be released
// HOLDOFF | all keys released, counting the hold-off period
module panel_key_seq #(
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] key_pedge,
    input  logic [5:0] key_filt,
    input  logic       run,
    input  logic       ack,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic       stop_req,
    output logic       rejected,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);

    state_t     state;
    logic [7:0] count;
    logic [2:0] sel_code;
    logic       any_edge;
    logic       any_down;
    logic       unused_stop_level;

    // STOP level is never used by the sequencer; only its edge matters
    assign unused_stop_level = key_filt[5];
    assign any_edge          = |key_pedge[4:0];
    assign any_down          = |key_filt[4:0];

    // lowest-index key wins when several edges arrive together
    always_comb begin
        sel_code = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (key_pedge[i]) begin
                sel_code = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 8'd0;
            cmd       <= 3'd0;
            cmd_valid <= 1'b0;
            stop_req  <= 1'b0;
            rejected  <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            stop_req <= key_pedge[5];
            rejected <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_edge) begin
                        busy <= 1'b1;
                        if (run) begin
                            rejected <= 1'b1;
                            state    <= RELEASE;
                        end else begin
                            cmd       <= sel_code;
                            cmd_valid <= 1'b1;
                            count     <= 8'd0;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // ack wins over a timeout landing in the same cycle
                    if (ack) begin
                        cmd       <= 3'd0;
                        cmd_valid <= 1'b0;
                        state     <= RELEASE;
                    end else if (count == ACK_LAST) begin
                        cmd       <= 3'd0;
                        cmd_valid <= 1'b0;
                        timeout   <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                RELEASE: begin
                    if (!any_down) begin
                        count <= 8'd0;
                        state <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (any_down) begin
                        state <= RELEASE;
                    end else if (count == HOLD_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: begin
                    cmd       <= 3'd0;
                    cmd_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_panel_key_seq.sv
// Scoreboard bench for panel_key_seq: a lockout model built on clean-cycle runs predicts
// command/pulse events; a negedge monitor pops and compares whatever the DUT presents.
module tb_panel_key_seq;

    localparam int HOLD = 16;
    localparam int ATO  = 8;

    localparam int EV_STOP  = 0;
    localparam int EV_REJ   = 1;
    localparam int EV_TMO   = 2;
    localparam int EV_START = 3;
    localparam int EV_END   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] key_pedge = 6'd0;
    logic [5:0] key_filt = 6'd0;
    logic       run = 1'b0;
    logic       ack = 1'b0;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       stop_req;
    logic       rejected;
    logic       timeout;
    logic       busy;

    panel_key_seq #(
        .HOLDOFF_CYCLES(HOLD),
        .ACK_TIMEOUT   (ATO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_pedge(key_pedge),
        .key_filt (key_filt),
        .run      (run),
        .ack      (ack),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .stop_req (stop_req),
        .rejected (rejected),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int code;
        int cyc;
    } ev_t;

    ev_t sbq[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    // reference model: a command is outstanding for at most ATO visible cycles;
    // after it (or a reject) the panel is locked until HOLD+1 consecutive key-free cycles
    bit  pending = 1'b0;
    bit  locked  = 1'b0;
    int  age     = 0;
    int  clean   = 0;
    int  m_code  = 0;
    bit  prev_valid = 1'b0;

    task automatic push_ev(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.code = c;
        e.cyc  = cyc;
        sbq.push_back(e);
    endtask

    task automatic model_step();
        if (rst) begin
            if (pending) push_ev(EV_END, 0);
            pending = 1'b0;
            locked  = 1'b0;
            age     = 0;
            clean   = 0;
            m_code  = 0;
            return;
        end
        if (key_pedge[5]) push_ev(EV_STOP, 0);
        if (locked) begin
            if (key_filt[4:0] == 5'd0) clean++;
            else clean = 0;
            if (clean == HOLD + 1) locked = 1'b0;
        end else if (pending) begin
            if (ack) begin
                pending = 1'b0;
                locked  = 1'b1;
                clean   = 0;
                m_code  = 0;
                push_ev(EV_END, 0);
            end else if (age == ATO) begin
                pending = 1'b0;
                locked  = 1'b1;
                clean   = 0;
                m_code  = 0;
                push_ev(EV_TMO, 0);
                push_ev(EV_END, 0);
            end else begin
                age++;
            end
        end else if (key_pedge[4:0] != 5'd0) begin
            if (run) begin
                push_ev(EV_REJ, 0);
                locked = 1'b1;
                clean  = 0;
            end else begin
                m_code = 0;
                for (int i = 0; i < 5; i++) begin
                    if (key_pedge[i]) begin
                        m_code = i + 1;
                        break;
                    end
                end
                pending = 1'b1;
                age     = 1;
                push_ev(EV_START, m_code);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        model_step();
    endtask

    task automatic got(input int k, input int c);
        ev_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d code=%0d at cycle %0d, required no event", k, c, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.kind != k || e.code != c || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got kind=%0d code=%0d cycle=%0d, required kind=%0d code=%0d cycle=%0d",
                         k, c, cyc, e.kind, e.code, e.cyc);
            end
        end
    endtask

    task automatic check_level(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    // monitor: levels every cycle, events popped from the scoreboard as they appear
    always @(negedge clk) begin
        if (cyc > 0) begin
            check_level("cmd_valid", int'(cmd_valid === 1'b1), int'(pending));
            check_level("busy", int'(busy === 1'b1), int'(pending | locked));
            check_level("cmd", (^cmd === 1'bx) ? -1 : int'(cmd), m_code);
            if (stop_req === 1'b1) got(EV_STOP, 0);
            if (rejected === 1'b1) got(EV_REJ, 0);
            if (timeout === 1'b1) got(EV_TMO, 0);
            if (cmd_valid === 1'b1 && !prev_valid) got(EV_START, int'(cmd));
            if (cmd_valid !== 1'b1 && prev_valid) got(EV_END, 0);
            prev_valid = (cmd_valid === 1'b1);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: got nothing at cycle %0d, required kind=%0d code=%0d",
                         cyc, sbq[0].kind, sbq[0].code);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic press(input logic [5:0] keys);
        key_pedge = keys;
        key_filt  = keys;
        tick();
        key_pedge = 6'd0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        logic [5:0] nl;
        int         b;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();

        // single DEP key, ack in the third visible cycle, key held 20 cycles
        press(6'b000100);
        tick();
        tick();
        pulse_ack();
        repeat (16) tick();
        key_filt = 6'd0;
        repeat (22) tick();

        // simultaneous keys: LOAD_ADD wins
        press(6'b011010);
        repeat (2) tick();
        pulse_ack();
        repeat (3) tick();
        key_filt = 6'd0;
        repeat (22) tick();

        // running: START rejected, STOP passes through in the same cycle
        run = 1'b1;
        key_pedge = 6'b100001;
        key_filt  = 6'b000001;
        tick();
        key_pedge = 6'd0;
        repeat (3) tick();
        key_filt = 6'd0;
        repeat (22) tick();
        run = 1'b0;

        // EXAM with no ack: timeout after ATO cycles
        press(6'b001000);
        repeat (12) tick();
        key_filt = 6'd0;
        repeat (22) tick();

        // CONT acked, bounce during hold-off, DEP edge in hold-off ignored
        press(6'b010000);
        tick();
        pulse_ack();
        key_filt = 6'd0;
        repeat (7) tick();
        key_filt = 6'b010000;
        tick();
        key_filt = 6'd0;
        repeat (3) tick();
        press(6'b000100);
        key_filt = 6'd0;
        repeat (25) tick();
        press(6'b000100);
        tick();
        pulse_ack();
        key_filt = 6'd0;
        repeat (22) tick();

        // reset while a command is outstanding, then a fresh START
        press(6'b000001);
        tick();
        rst = 1'b1;
        key_pedge = 6'b100010;
        tick();
        rst = 1'b0;
        key_pedge = 6'd0;
        key_filt = 6'd0;
        tick();
        press(6'b000001);
        tick();
        pulse_ack();
        key_filt = 6'd0;
        repeat (22) tick();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            nl = key_filt;
            for (int k = 0; k < 6; k++) begin
                if (nl[k]) begin
                    if ($urandom_range(0, 5) == 0) nl[k] = 1'b0;
                end else if ($urandom_range(0, 149) == 0) begin
                    nl[k] = 1'b1;
                end
            end
            key_pedge = nl & ~key_filt;
            if ($urandom_range(0, 49) == 0) begin
                b = int'($urandom_range(0, 5));
                key_pedge[b] = 1'b1;
            end
            key_filt = nl;
            if ($urandom_range(0, 59) == 0) run = ~run;
            if (((n / 500) % 2) == 0) ack = ($urandom_range(0, 2) == 0);
            else ack = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end

        rst = 1'b0;
        ack = 1'b0;
        key_pedge = 6'd0;
        key_filt = 6'd0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending events, required 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
